megaduck_snd_wrq: RTL and testbench

- Write queue between the MegaDuck address/data swizzle stage and the APU register interface.
- Captures CPU writes already translated to GB sound addresses (FF10–FF3F) and nybble-corrected data on clk_sys.
- Replays them to the APU one per APU clock-enable, so APU register updates stay aligned to the APU's own enable cadence.
- Exposes a pending flag so the CPU read path can stall sound-register reads until the queue has drained.

---
 rtl/megaduck_snd_wrq.sv | 97 +++++++++
 tb/tb_megaduck_snd_wrq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/megaduck_snd_wrq.sv
// Sound-register write queue: captures swizzled CPU writes to FF10..FF3F on clk_sys
// and replays them to the APU one entry per snd_ce, in strict program order.
module megaduck_snd_wrq #(
  parameter  int DEPTH = 4,
  localparam int PTRW  = $clog2(DEPTH)
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpu_ce,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        snd_ce,
  output logic        snd_wr,
  output logic [5:0]  snd_addr,
  output logic [7:0]  snd_dout,
  output logic        pending,
  output logic        full,
  output logic        ovf,
  input  logic        ovf_clr
);

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } wrq_ent_t;

  localparam logic [PTRW:0] FULL_CNT = DEPTH[PTRW:0];

  wrq_ent_t            mem_q [DEPTH];
  logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTRW:0]       count_q, count_d;
  logic                pending_q, pending_d;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;

  logic     in_range, push_req, push, pop, ovf_set;
  wrq_ent_t ent_in, head;

  always_comb begin
    in_range = (cpu_addr >= 16'hFF10) && (cpu_addr <= 16'hFF3F);
    push_req = cpu_ce & cpu_wr & in_range;
    pop      = snd_ce & (count_q != '0);
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    push     = push_req & ((count_q != FULL_CNT) | pop);
    ovf_set  = push_req & (count_q == FULL_CNT) & ~pop;

    // Low six bits of FF10 are 0x10, so the offset fits modulo 64.
    ent_in.addr = cpu_addr[5:0] - 6'h10;
    ent_in.data = cpu_din;

    wr_ptr_d  = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
    count_d   = count_q + {{PTRW{1'b0}}, push} - {{PTRW{1'b0}}, pop};
    pending_d = (count_d != '0);
    full_d    = (count_d == FULL_CNT);

    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset; the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= ent_in;
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    snd_wr   = pop;
    snd_addr = (count_q != '0) ? head.addr : 6'h00;
    snd_dout = (count_q != '0) ? head.data : 8'h00;
    pending  = pending_q;
    full     = full_q;
    ovf      = ovf_q;
  end

endmodule

// File: tb/tb_megaduck_snd_wrq.sv
// Directed bench for megaduck_snd_wrq: inputs change on the falling edge, outputs
// are checked 1ns later, well before the next rising edge.
module tb_megaduck_snd_wrq;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_ce = 1'b0, cpu_wr = 1'b0, snd_ce = 1'b0, ovf_clr = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_din = 8'h00;
  logic        snd_wr, pending, full, ovf;
  logic [5:0]  snd_addr;
  logic [7:0]  snd_dout;

  int checks = 0;
  int errors = 0;

  megaduck_snd_wrq #(.DEPTH(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cpu_ce(cpu_ce), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .snd_ce(snd_ce), .snd_wr(snd_wr),
    .snd_addr(snd_addr), .snd_dout(snd_dout), .pending(pending), .full(full),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk_sys = ~clk_sys;

  // Drive one cycle of inputs at the falling edge, then settle 1ns for checks.
  task automatic cyc(input logic ce, input logic wr, input logic [15:0] a,
                     input logic [7:0] d, input logic sce, input logic clr = 1'b0);
    @(negedge clk_sys);
    cpu_ce = ce; cpu_wr = wr; cpu_addr = a; cpu_din = d; snd_ce = sce; ovf_clr = clr;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({snd_wr, snd_addr, snd_dout, pending, full, ovf} !== 18'h0) begin
      errors++;
      $display("FAIL reset_state: got wr=%b addr=%h dout=%h pend=%b full=%b ovf=%b, want all 0",
               snd_wr, snd_addr, snd_dout, pending, full, ovf);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    cyc(1, 1, 16'hFF24, 8'h77, 0);
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL single_pre_pending: got %b want 0", pending); end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 16'h0000, 8'h00, 0);
      checks++;
      if ({pending, snd_wr} !== 2'b10) begin
        errors++; $display("FAIL single_hold[%0d]: got pend=%b wr=%b want pend=1 wr=0", i, pending, snd_wr);
      end
    end
    cyc(0, 0, 16'h0000, 8'h00, 1);
    checks++;
    if ({snd_wr, snd_addr, snd_dout} !== {1'b1, 6'h14, 8'h77}) begin
      errors++; $display("FAIL single_pop: got wr=%b addr=%h dout=%h want 1/14/77", snd_wr, snd_addr, snd_dout);
    end
    cyc(0, 0, 16'h0000, 8'h00, 1);
    checks++;
    if ({pending, snd_wr} !== 2'b00) begin
      errors++; $display("FAIL single_after: got pend=%b wr=%b want 0/0", pending, snd_wr);
    end
  endtask

  task automatic test_filter();
    cyc(1, 1, 16'hFF40, 8'hA5, 0);
    cyc(1, 1, 16'hFF0F, 8'hA5, 0);
    cyc(1, 1, 16'hFF45, 8'hA5, 0);
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL filter_reject: got pend=%b want 0", pending); end
    cyc(1, 1, 16'hFF3F, 8'hA5, 0);
    cyc(0, 0, 16'h0000, 8'h00, 1);
    checks++;
    if ({snd_wr, snd_addr, snd_dout} !== {1'b1, 6'h2F, 8'hA5}) begin
      errors++; $display("FAIL filter_pop: got wr=%b addr=%h dout=%h want 1/2f/a5", snd_wr, snd_addr, snd_dout);
    end
    cyc(0, 0, 16'h0000, 8'h00, 1);
    checks++;
    if ({pending, snd_wr} !== 2'b00) begin
      errors++; $display("FAIL filter_single: got pend=%b wr=%b want 0/0", pending, snd_wr);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 16'hFF10 + 16'(i), 8'(i + 1), 0);
      checks++;
      if ({full, ovf} !== {(i == 4), 1'b0}) begin
        errors++; $display("FAIL fill_state[%0d]: got full=%b ovf=%b want full=%b ovf=0", i, full, ovf, (i == 4));
      end
    end
    cyc(0, 0, 16'h0000, 8'h00, 0);
    checks++;
    if ({full, ovf, pending} !== 3'b111) begin
      errors++; $display("FAIL ovf_set: got full=%b ovf=%b pend=%b want 1/1/1", full, ovf, pending);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 16'h0000, 8'h00, 1);
      checks++;
      if ({snd_wr, snd_addr, snd_dout} !== {1'b1, 6'(i), 8'(i + 1)}) begin
        errors++; $display("FAIL fill_drain[%0d]: got wr=%b addr=%h dout=%h want 1/%h/%h",
                           i, snd_wr, snd_addr, snd_dout, 6'(i), 8'(i + 1));
      end
    end
    cyc(0, 0, 16'h0000, 8'h00, 1);
    checks++;
    if ({snd_wr, pending, full, ovf} !== 4'b0001) begin
      errors++; $display("FAIL fill_empty: got wr=%b pend=%b full=%b ovf=%b want 0/0/0/1", snd_wr, pending, full, ovf);
    end
    cyc(0, 0, 16'h0000, 8'h00, 0, 1);
    cyc(0, 0, 16'h0000, 8'h00, 0);
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got ovf=%b want 0", ovf); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) cyc(1, 1, 16'hFF10 + 16'(i), 8'h11 + 8'(i), 0);
    cyc(1, 1, 16'hFF30, 8'h9C, 1);
    checks++;
    if ({snd_wr, snd_addr, snd_dout} !== {1'b1, 6'h00, 8'h11}) begin
      errors++; $display("FAIL pp_pop: got wr=%b addr=%h dout=%h want 1/00/11", snd_wr, snd_addr, snd_dout);
    end
    cyc(0, 0, 16'h0000, 8'h00, 0);
    checks++;
    if ({full, ovf} !== 2'b10) begin
      errors++; $display("FAIL pp_state: got full=%b ovf=%b want 1/0", full, ovf);
    end
    for (int i = 0; i < 4; i++) begin
      logic [5:0] ea;
      logic [7:0] ed;
      ea = (i == 3) ? 6'h20 : 6'(i + 1);
      ed = (i == 3) ? 8'h9C : 8'h12 + 8'(i);
      cyc(0, 0, 16'h0000, 8'h00, 1);
      checks++;
      if ({snd_wr, snd_addr, snd_dout} !== {1'b1, ea, ed}) begin
        errors++; $display("FAIL pp_drain[%0d]: got wr=%b addr=%h dout=%h want 1/%h/%h",
                           i, snd_wr, snd_addr, snd_dout, ea, ed);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) cyc(1, 1, 16'hFF10 + 16'(k), 8'h40 + 8'(k), 1);
      else       cyc(0, 0, 16'h0000, 8'h00, 1);
      checks++;
      if (k == 0) begin
        if ({snd_wr, pending} !== 2'b00) begin
          errors++; $display("FAIL b2b_first: got wr=%b pend=%b want 0/0", snd_wr, pending);
        end
      end else if ({snd_wr, snd_addr, snd_dout, full} !== {1'b1, 6'(k - 1), 8'h40 + 8'(k - 1), 1'b0}) begin
        errors++; $display("FAIL b2b[%0d]: got wr=%b addr=%h dout=%h full=%b want 1/%h/%h/0",
                           k, snd_wr, snd_addr, snd_dout, full, 6'(k - 1), 8'h40 + 8'(k - 1));
      end
    end
    cyc(0, 0, 16'h0000, 8'h00, 1);
    checks++;
    if ({snd_wr, pending, ovf} !== 3'b000) begin
      errors++; $display("FAIL b2b_end: got wr=%b pend=%b ovf=%b want 0/0/0", snd_wr, pending, ovf);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) cyc(1, 1, 16'hFF20 + 16'(i), 8'hC0 + 8'(i), 0);
    cyc(0, 0, 16'h0000, 8'h00, 1);
    checks++;
    if ({snd_wr, pending} !== 2'b11) begin
      errors++; $display("FAIL rst_pre: got wr=%b pend=%b want 1/1", snd_wr, pending);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({snd_wr, pending, full, ovf} !== 4'b0000) begin
      errors++; $display("FAIL rst_async: got wr=%b pend=%b full=%b ovf=%b want 0/0/0/0", snd_wr, pending, full, ovf);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 16'h0000, 8'h00, 1);
      checks++;
      if ({snd_wr, snd_addr, snd_dout, pending} !== 16'h0) begin
        errors++; $display("FAIL rst_after[%0d]: got wr=%b addr=%h dout=%h pend=%b want all 0",
                           i, snd_wr, snd_addr, snd_dout, pending);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_filter();
    test_fill_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
